// File: rtl/key_pkg.sv
// ============================================================================
// Module : key_pkg
// Brief  : Shared state encoding and default timing constants for the key
//          debounce array.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_pkg;

    localparam int c_db_cycles_def   = 1000000;   // 20 ms at 50 MHz
    localparam int c_long_cycles_def = 50000000;  // 1 s at 50 MHz

    localparam logic [1:0] c_st_idle         = 2'd0;
    localparam logic [1:0] c_st_press_wait   = 2'd1;
    localparam logic [1:0] c_st_held         = 2'd2;
    localparam logic [1:0] c_st_release_wait = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE         = c_st_idle,
        ST_PRESS_WAIT   = c_st_press_wait,
        ST_HELD         = c_st_held,
        ST_RELEASE_WAIT = c_st_release_wait
    } key_state_e;

endpackage

`default_nettype wire

// File: rtl/key_debounce_ch.sv
// ============================================================================
// Module : key_debounce_ch
// Brief  : One debounce channel: 2-flop synchronizer, press/release FSM with a
//          saturating stability counter, optional long-press detector enabled
//          by macro KEY_LONGPRESS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DB_CYCLES   = c_db_cycles_def,
    parameter int LONG_CYCLES = c_long_cycles_def
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int c_cnt_w = $clog2(DB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_cfg
        $error("key_debounce_ch: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
    end

    logic [1:0]         sync_q,    sync_d;
    key_state_e         state_q,   state_d;
    logic [c_cnt_w-1:0] cnt_q,     cnt_d;
    logic               level_q,   level_d;
    logic               press_q,   press_d;
    logic               release_q, release_d;
    logic               w_pressed;
    logic [c_cnt_w-1:0] w_cnt_inc;

    assign sync_d    = {sync_q[0], i_key_n};
    assign w_pressed = ~sync_q[1];
    assign w_cnt_inc = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + c_cnt_one;

    // Acceptance is tested on the registered count so the pulse lands
    // DB_CYCLES+2 cycles after the raw edge is first sampled.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pressed) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = c_cnt_one;
                end
            end
            ST_PRESS_WAIT: begin
                if (cnt_q == c_cnt_max) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else if (!w_pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!w_pressed) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = c_cnt_one;
                end
            end
            ST_RELEASE_WAIT: begin
                if (cnt_q == c_cnt_max) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else if (w_pressed) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;

`ifdef KEY_LONGPRESS_EN
    localparam int c_long_w = $clog2(LONG_CYCLES + 1);
    localparam logic [c_long_w-1:0] c_long_last = c_long_w'(LONG_CYCLES - 1);
    localparam logic [c_long_w-1:0] c_long_max  = c_long_w'(LONG_CYCLES);
    localparam logic [c_long_w-1:0] c_long_one  = c_long_w'(1);

    logic [c_long_w-1:0] long_cnt_q, long_cnt_d;
    logic                long_q,     long_d;

    // Counter is zero in the key_press cycle and saturates, so the pulse fires once.
    always_comb begin
        long_cnt_d = '0;
        long_d     = 1'b0;
        if (state_q == ST_HELD && state_d == ST_HELD) begin
            long_cnt_d = (long_cnt_q == c_long_max) ? long_cnt_q : long_cnt_q + c_long_one;
        end
        if (state_q == ST_HELD && long_cnt_q == c_long_last) begin
            long_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign o_long = long_q;
`else
    assign o_long = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/key_debounce_array.sv
// ============================================================================
// Module : key_debounce_array
// Brief  : N_KEYS independent push-button debouncers with press/release/long
//          pulses; long-press detection enabled by macro KEY_LONGPRESS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS      = 2,
    parameter int DB_CYCLES   = c_db_cycles_def,
    parameter int LONG_CYCLES = c_long_cycles_def
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    if (N_KEYS < 1 || N_KEYS > 32) begin : g_bad_n_keys
        $error("key_debounce_array: N_KEYS must be in 1..32");
    end

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_key_n   (key_n[gi]),
            .o_level   (key_level[gi]),
            .o_press   (key_press[gi]),
            .o_release (key_release[gi]),
            .o_long    (key_long[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_array.sv
// ============================================================================
// Module : tb_key_debounce_array
// Brief  : Directed self-checking bench for key_debounce_array (N_KEYS=2,
//          DB_CYCLES=4, LONG_CYCLES=16); long-press expectations follow
//          macro KEY_LONGPRESS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_debounce_array;

    localparam int c_n    = 2;
    localparam int c_db   = 4;
    localparam int c_long = 16;
`ifdef KEY_LONGPRESS_EN
    localparam bit c_long_en = 1'b1;
`else
    localparam bit c_long_en = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [c_n-1:0] key_n;
    logic [c_n-1:0] key_level;
    logic [c_n-1:0] key_press;
    logic [c_n-1:0] key_release;
    logic [c_n-1:0] key_long;

    int n_vec  = 0;
    int n_miss = 0;

    key_debounce_array #(
        .N_KEYS      (c_n),
        .DB_CYCLES   (c_db),
        .LONG_CYCLES (c_long)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                              input logic [1:0] rel, input logic [1:0] lng);
        check_vec({tag, ".level"},   32'(key_level),   32'(lvl));
        check_vec({tag, ".press"},   32'(key_press),   32'(prs));
        check_vec({tag, ".release"}, 32'(key_release), 32'(rel));
        check_vec({tag, ".long"},    32'(key_long),    32'(lng));
    endtask

    // Press keys in mask at edge 0, release them at edge 'hold'.
    task automatic run_hold(input string tag, input logic [1:0] mask, input int hold, input int total);
        logic [1:0] lvl, prs, rel, lng;
        key_n = ~mask;
        for (int k = 0; k < total; k++) begin
            if (k == hold) key_n = 2'b11;
            tick();
            lvl = (k >= c_db + 2 && k < hold + c_db + 2) ? mask : 2'b00;
            prs = (k == c_db + 2) ? mask : 2'b00;
            rel = (k == hold + c_db + 2) ? mask : 2'b00;
            lng = (c_long_en && hold >= c_db + c_long && k == c_db + 2 + c_long) ? mask : 2'b00;
            check_outs(tag, lvl, prs, rel, lng);
        end
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 2'b11;
        repeat (3) begin
            tick();
            check_outs("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            check_outs("idle", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        run_hold("press_k0", 2'b01, 10, 20);

        // Bounce: low 3, high 1, low 3, then released
        for (int k = 0; k < 16; k++) begin
            key_n = {1'b1, (k == 3 || k >= 7)};
            tick();
            check_outs("glitch", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        run_hold("both_keys", 2'b11, 30, 40);
        run_hold("hold40_k1", 2'b10, 40, 50);

        // Key held through reset release
        rst   = 1'b1;
        key_n = 2'b01;
        repeat (3) begin
            tick();
            check_outs("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_outs("after_rst", (k >= 6) ? 2'b10 : 2'b00, (k == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00);
        end

        // Reset mid-hold: level drops, no release pulse
        rst = 1'b1;
        repeat (3) begin
            tick();
            check_outs("rst_mid_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Reset mid-debounce
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs("pre_abort", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b1;
        repeat (8) begin
            tick();
            check_outs("rst_mid_db", 2'b00, 2'b00, 2'b00, 2'b00);
        end
        key_n = 2'b11;
        rst   = 1'b0;
        repeat (10) begin
            tick();
            check_outs("post_abort", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
